// File: rtl/ofm_packer.sv
// ofm_packer: queues whole OFM vectors and serializes them onto output words.
// Optional OFM_PACK_CNT_EN adds a vec_count output of completed vectors.
module ofm_packer #(
  parameter int NUM_OF_OUTPUTS = 9,
  parameter int OFM_WIDTH      = 8,
  parameter int OUTPUT_WIDTH   = 32,
  parameter int DEPTH          = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [NUM_OF_OUTPUTS*OFM_WIDTH-1:0] ofm_input,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [OUTPUT_WIDTH-1:0]             ofm_output,
`ifdef OFM_PACK_CNT_EN
  output logic [15:0]                         vec_count,
`endif
  output logic                                out_last
);

  localparam int VW    = NUM_OF_OUTPUTS * OFM_WIDTH;
  localparam int LANES = OUTPUT_WIDTH / OFM_WIDTH;
  localparam int WORDS = (NUM_OF_OUTPUTS + LANES - 1) / LANES;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int XW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  logic [VW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [XW-1:0] idx_q, idx_d;
  logic          live_q;
  logic          push, hs, pop, last;
  logic [WORDS*OUTPUT_WIDTH-1:0] pad;

  // live_q keeps in_ready low until the first edge after reset release
  assign in_ready  = live_q && (cnt_q != CW'(DEPTH));
  assign out_valid = (cnt_q != '0);
  assign last      = (idx_q == XW'(WORDS - 1));
  assign out_last  = out_valid && last;
  assign push      = in_valid && in_ready;
  assign hs        = out_valid && out_ready;
  assign pop       = hs && last;

  always_comb begin
    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    idx_d = idx_q;
    if (hs) idx_d = last ? '0 : idx_q + 1'b1;
    cnt_d = cnt_q;
    unique case (1'b1)
      (push && !pop): cnt_d = cnt_q + 1'b1;
      (pop && !push): cnt_d = cnt_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      live_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      live_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= ofm_input;
  end

  // element k sits at bit k*OFM_WIDTH of the zero-padded head entry
  always_comb begin
    pad           = '0;
    pad[VW-1:0]   = mem_q[rd_q];
    ofm_output    = '0;
    if (out_valid) begin
      for (int w = 0; w < WORDS; w++) begin
        if (idx_q == XW'(w))
          ofm_output = pad[w*OUTPUT_WIDTH +: OUTPUT_WIDTH];
      end
    end
  end

`ifdef OFM_PACK_CNT_EN
  logic [15:0] vc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   vc_q <= '0;
    else if (pop) vc_q <= vc_q + 16'd1;
  end

  assign vec_count = vc_q;
`endif

endmodule

// File: tb/tb_ofm_packer.sv
// tb_ofm_packer: directed and random stimulus against a queue-based model.
// Model holds whole vectors and derives each word from element positions.
module tb_ofm_packer;
  localparam int N  = 9;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int L  = 4;
  localparam int WD = 3;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        out_ready = 0;
  logic [71:0] ofm_input = '0;
  logic        in_ready, out_valid, out_last;
  logic [31:0] ofm_output;
`ifdef OFM_PACK_CNT_EN
  logic [15:0] vec_count;
`endif

  ofm_packer dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .ofm_input(ofm_input),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .ofm_output(ofm_output),
`ifdef OFM_PACK_CNT_EN
    .vec_count(vec_count),
`endif
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;
  int failed = 0;
  logic [71:0] q[$];
  int widx = 0;
  bit live = 0;
  int vc = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(logic [71:0] v, int w);
    logic [31:0] r = '0;
    for (int j = 0; j < L; j++) begin
      int k = w * L + j;
      if (k < N) r[j*W +: W] = v[k*W +: W];
    end
    return r;
  endfunction

  function automatic logic [71:0] seq_vec(bit neg);
    logic [71:0] v;
    for (int k = 0; k < N; k++)
      v[k*W +: W] = neg ? 8'(-(k + 1)) : 8'(k + 1);
    return v;
  endfunction

  function automatic logic [71:0] rnd_vec();
    logic [71:0] v;
    v = {$urandom(), $urandom(), $urandom()};
    return v;
  endfunction

  // check outputs of the current cycle, drive inputs, advance one cycle
  task automatic step(bit iv, logic [71:0] v, bit ordy);
    bit ev, er;
    logic [31:0] ew;
    ev = (q.size() != 0);
    er = live && (q.size() != D);
    ew = ev ? word_of(q[0], widx) : 32'h0;
    check("out_valid", {31'b0, out_valid}, {31'b0, ev});
    check("in_ready", {31'b0, in_ready}, {31'b0, er});
    check("ofm_output", ofm_output, ew);
    check("out_last", {31'b0, out_last}, {31'b0, ev && widx == WD - 1});
`ifdef OFM_PACK_CNT_EN
    check("vec_count", {16'b0, vec_count}, 32'(vc));
`endif
    in_valid = iv;
    ofm_input = v;
    out_ready = ordy;
    if (ev && ordy) begin
      if (widx == WD - 1) begin
        q.delete(0);
        widx = 0;
        vc = (vc + 1) % 65536;
      end else widx++;
    end
    if (iv && er) q.push_back(v);
    live = 1;
    @(negedge clk);
  endtask

  task automatic push_hold(logic [71:0] v, bit ordy);
    bit acc = 0;
    int n = 0;
    while (!acc && n < 50) begin
      acc = live && (q.size() != D);
      step(1, v, ordy);
      n++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      step(0, '0, 1);
      n++;
    end
    step(0, '0, 1);
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    check("rst out_valid", {31'b0, out_valid}, 32'h0);
    check("rst ofm_output", ofm_output, 32'h0);
    check("rst out_last", {31'b0, out_last}, 32'h0);
    check("rst in_ready", {31'b0, in_ready}, 32'h0);
`ifdef OFM_PACK_CNT_EN
    check("rst vec_count", {16'b0, vec_count}, 32'h0);
`endif
    in_valid = 0;
    out_ready = 0;
    q.delete();
    widx = 0;
    live = 0;
    vc = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    logic [71:0] vr[5];

    repeat (2) @(negedge clk);
    check("init out_valid", {31'b0, out_valid}, 32'h0);
    check("init in_ready", {31'b0, in_ready}, 32'h0);
    check("init ofm_output", ofm_output, 32'h0);
    rst_n = 1;
    step(0, '0, 1);

    step(1, seq_vec(0), 1);
    check("pos w0", ofm_output, 32'h04030201);
    step(0, '0, 1);
    check("pos w1", ofm_output, 32'h08070605);
    step(0, '0, 1);
    check("pos w2", ofm_output, 32'h00000009);
    check("pos last", {31'b0, out_last}, 32'h1);
    step(0, '0, 1);
    check("pos idle", ofm_output, 32'h0);

    step(1, seq_vec(1), 1);
    check("neg w0", ofm_output, 32'hFCFDFEFF);
    step(0, '0, 1);
    step(0, '0, 1);
    check("neg w2", ofm_output, 32'h000000F7);
    step(0, '0, 1);

    step(1, seq_vec(0), 1);
    step(0, '0, 1);
    for (int i = 0; i < 5; i++) begin
      check("stall word", ofm_output, 32'h08070605);
      check("stall last", {31'b0, out_last}, 32'h0);
      step(0, '0, 0);
    end
    drain();

    for (int i = 0; i < 5; i++) vr[i] = rnd_vec();
    for (int i = 0; i < 4; i++) step(1, vr[i], 0);
    check("full in_ready", {31'b0, in_ready}, 32'h0);
    step(1, vr[4], 0);
    push_hold(vr[4], 1);
    drain();

    for (int i = 0; i < 3; i++) step(1, rnd_vec(), 0);
    repeat (4) step(0, '0, 1);
    check("mid idx", {31'b0, out_last}, 32'h0);
    do_reset();
    step(0, '0, 1);
    step(0, '0, 1);

    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), rnd_vec(), 1'($urandom_range(0, 3) != 0));
    drain();

`ifdef OFM_PACK_CNT_EN
    force dut.vc_q = 16'hFFFF;
    #1 release dut.vc_q;
    vc = 65535;
    @(negedge clk);
    step(1, seq_vec(0), 1);
    drain();
    check("vec_count wrap", {16'b0, vec_count}, 32'h0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ofm_packer.md
# ofm_packer

Output-side packing stage between the ReLU stage and the accelerator's 32-bit output port. Accepts one parallel vector of NUM_OF_OUTPUTS activated OFM bytes per handshake and queues whole vectors in a small FIFO. Serializes each vector onto OUTPUT_WIDTH-bit words with a valid/ready handshake, so the PE/ReLU pipeline is decoupled from downstream backpressure.

## Interface
- NUM_OF_OUTPUTS, 9, elements per input vector
- OFM_WIDTH, 8, bits per element, passed through unmodified as a signed byte
- OUTPUT_WIDTH, 32, output word width; must be a multiple of OFM_WIDTH
- DEPTH, 4, FIFO capacity in whole vectors; power of two, ≥2
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  ofm_input holds a valid vector
- in_ready  output  1  packer can accept a vector this cycle
- ofm_input  input  NUM_OF_OUTPUTS*OFM_WIDTH  flattened vector; element k occupies [k*OFM_WIDTH +: OFM_WIDTH]
- out_valid  output  1  ofm_output holds a valid word
- out_ready  input  1  downstream accepts the word
- ofm_output  output  OUTPUT_WIDTH  packed word
- out_last  output  1  current word is the last word of its vector

## Operation
- LANES = OUTPUT_WIDTH/OFM_WIDTH (4). WORDS = ceil(NUM_OF_OUTPUTS/LANES) (3).
- Storage: DEPTH vector entries, write pointer, read pointer, occupancy count (0..DEPTH), and word index (0..WORDS-1).
- Push: occurs when in_valid && in_ready. Writes ofm_input at the write pointer and advances the pointer, wrapping modulo DEPTH.
- in_ready = (count != DEPTH). It is derived only from registered count. A pop in the same cycle does not free a slot for that cycle's push.
- Output: out_valid = (count != 0).
  - Word w of the head entry places element w*LANES+j in lane j, at bits [j*OFM_WIDTH +: OFM_WIDTH].
  - Lanes past NUM_OF_OUTPUTS are zero.
  - When out_valid=0, ofm_output = 0.
- out_last = out_valid && (word index == WORDS-1).
- Word handshake: occurs when out_valid && out_ready.
  - If the word is not the last, the word index increments.
  - If the word is last, the word index returns to 0, the head entry is popped, and the read pointer advances, wrapping.
- Count update:
  - Push only: count +1.
  - Pop only: count −1.
  - Push and pop in the same cycle: count unchanged.
- While out_valid=1 and out_ready=0, ofm_output and out_last must hold stable.
- There is no combinational path from any input to ofm_output, out_valid, or out_last.
- Effective states:
  - EMPTY (count=0).
  - SENDING (count>0, word index advancing).
  - FULL (count=DEPTH, in_ready=0; output side continues to drain).

## Timing
- Reset (rst_n low, asynchronous): count=0, pointers=0, word index=0, out_valid=0, ofm_output=0, out_last=0, in_ready=0. in_ready rises to 1 in the first cycle after release.
- Latency: a vector pushed at edge N presents word 0 (out_valid=1) in the cycle after edge N if the FIFO was empty. Otherwise it follows the queued vectors.
- Throughput: one word per cycle with out_ready held high. Each vector takes WORDS cycles.
- Boundary conditions:
  - Reset mid-vector discards all queued data and the partial word index.
  - Asserting in_valid while in_ready=0 has no effect. The source must hold its data.
  - Pointer wrap from DEPTH-1 to 0 is seamless.

## Configuration
- OFM_PACK_CNT_EN defined:
  - Adds output vec_count [15:0], reset 0.
  - vec_count increments on every last-word handshake and wraps 0xFFFF→0x0000.
- OFM_PACK_CNT_EN undefined: the vec_count port and its counter are absent. All other behaviour is identical.

## Test plan
- Single vector, elements 1..9, out_ready=1 → words 0x04030201, 0x08070605, 0x00000009 on three consecutive cycles, out_last only on the third; then out_valid=0 and ofm_output=0.
- Negative values −1..−9 (0xFF..0xF7) → first word 0xFCFDFEFF, third word 0x000000F7; sign bytes are not extended into the pad lanes.
- out_ready=0 for 5 cycles mid-vector (on word 1) → ofm_output=0x08070605 and out_last=0 held stable; resumes with word 2 when out_ready=1.
- out_ready=0 while pushing 5 vectors back-to-back → in_ready falls after the 4th push and the 5th is held; when drained, all 4 vectors emerge in order, then the 5th is accepted.
- Full FIFO, push attempt in the same cycle as the last-word pop → push is rejected that cycle (in_ready=0), count goes 4→3, and the push is accepted on the next cycle.
- rst_n pulsed low during word 1 of the second of three queued vectors → out_valid=0 immediately; after release the FIFO is empty. With OFM_PACK_CNT_EN, vec_count returns to 0. A separate run forcing vec_count to 0xFFFF then completing one vector reads 0x0000.
